// File: rtl/pipe_stall_ctrl_if.sv
// Hazard inputs and stall/flush controls between the pipeline and its stall sequencer.
interface pipe_stall_ctrl_if #(
    parameter int unsigned CW = 16
);
    // Hazard sources
    logic          icache_hit;
    logic          mem_req;
    logic          dcache_hit;
    logic          ld_use;
    logic          br_taken;
    // Pipeline controls
    logic          pc_en;
    logic          en_ifid;
    logic          en_idex;
    logic          en_exmem;
    logic          en_memwb;
    logic          flush_ifid;
    logic          flush_idex;
    logic          flush_exmem;
    logic          ifill;
    logic          dfill;
    logic [CW-1:0] stall_cnt;

    // Pipeline side: raises hazards, consumes controls
    modport master (
        output icache_hit, mem_req, dcache_hit, ld_use, br_taken,
        input  pc_en, en_ifid, en_idex, en_exmem, en_memwb,
        input  flush_ifid, flush_idex, flush_exmem, ifill, dfill, stall_cnt
    );

    // Sequencer side
    modport slave (
        input  icache_hit, mem_req, dcache_hit, ld_use, br_taken,
        output pc_en, en_ifid, en_idex, en_exmem, en_memwb,
        output flush_ifid, flush_idex, flush_exmem, ifill, dfill, stall_cnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: freezes on cache misses for
// MISS_LAT cycles, inserts load-use bubbles, flushes on taken branches and
// counts PC-stall cycles.
module pipe_stall_ctrl #(
    parameter int unsigned MISS_LAT = 4,
    parameter int unsigned CW       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_stall_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(MISS_LAT - 1);
    localparam logic [CW-1:0]    STALL_MAX = {CW{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_IWAIT = 2'd2
    } state_e;

    state_e          st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]   stall_cnt_q, stall_cnt_d;

    logic pc_en_c, en_ifid_c, en_idex_c, en_exmem_c, en_memwb_c;
    logic flush_ifid_c, flush_idex_c, flush_exmem_c, ifill_c, dfill_c;
    logic dmiss_c;

    assign dmiss_c = bus.mem_req & ~bus.dcache_hit;

    // Next state, refill countdown and pipeline controls
    always_comb begin
        st_d          = st_q;
        cnt_d         = cnt_q;
        pc_en_c       = 1'b0;
        en_ifid_c     = 1'b0;
        en_idex_c     = 1'b0;
        en_exmem_c    = 1'b0;
        en_memwb_c    = 1'b0;
        flush_ifid_c  = 1'b0;
        flush_idex_c  = 1'b0;
        flush_exmem_c = 1'b0;
        ifill_c       = 1'b0;
        dfill_c       = 1'b0;

        unique case (st_q)
            ST_RUN: begin
                if (dmiss_c) begin
                    // Whole pipe freezes in the miss cycle itself
                    st_d  = ST_DWAIT;
                    cnt_d = CNT_LOAD;
                end else if (bus.br_taken) begin
                    // Wrong-path fetch and hazards are discarded
                    pc_en_c       = 1'b1;
                    en_ifid_c     = 1'b1;
                    en_idex_c     = 1'b1;
                    en_exmem_c    = 1'b1;
                    en_memwb_c    = 1'b1;
                    flush_ifid_c  = 1'b1;
                    flush_idex_c  = 1'b1;
                    flush_exmem_c = 1'b1;
                end else if (!bus.icache_hit) begin
                    // Front end holds; back end drains
                    en_idex_c    = 1'b1;
                    en_exmem_c   = 1'b1;
                    en_memwb_c   = 1'b1;
                    flush_idex_c = bus.ld_use;
                    st_d         = ST_IWAIT;
                    cnt_d        = CNT_LOAD;
                end else if (bus.ld_use) begin
                    en_idex_c    = 1'b1;
                    en_exmem_c   = 1'b1;
                    en_memwb_c   = 1'b1;
                    flush_idex_c = 1'b1;
                end else begin
                    pc_en_c    = 1'b1;
                    en_ifid_c  = 1'b1;
                    en_idex_c  = 1'b1;
                    en_exmem_c = 1'b1;
                    en_memwb_c = 1'b1;
                end
            end

            ST_DWAIT: begin
                // Frozen; a held branch is taken up again in RUN after refill
                if (cnt_q == '0) begin
                    dfill_c = 1'b1;
                    st_d    = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_IWAIT: begin
                if (!dmiss_c && bus.br_taken) begin
                    // Redirect abandons the pending I-refill
                    pc_en_c       = 1'b1;
                    en_ifid_c     = 1'b1;
                    en_idex_c     = 1'b1;
                    en_exmem_c    = 1'b1;
                    en_memwb_c    = 1'b1;
                    flush_ifid_c  = 1'b1;
                    flush_idex_c  = 1'b1;
                    flush_exmem_c = 1'b1;
                    st_d          = ST_RUN;
                    cnt_d         = '0;
                end else begin
                    // Back end feeds bubbles unless a D-miss freezes it; the
                    // I-refill counter runs regardless
                    if (!dmiss_c) begin
                        en_idex_c    = 1'b1;
                        en_exmem_c   = 1'b1;
                        en_memwb_c   = 1'b1;
                        flush_idex_c = 1'b1;
                    end
                    if (cnt_q == '0) begin
                        ifill_c = 1'b1;
                        st_d    = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end

            default: begin
                st_d  = ST_RUN;
                cnt_d = '0;
            end
        endcase

        // Reset forces every control low immediately
        if (!rst_n) begin
            pc_en_c       = 1'b0;
            en_ifid_c     = 1'b0;
            en_idex_c     = 1'b0;
            en_exmem_c    = 1'b0;
            en_memwb_c    = 1'b0;
            flush_ifid_c  = 1'b0;
            flush_idex_c  = 1'b0;
            flush_exmem_c = 1'b0;
            ifill_c       = 1'b0;
            dfill_c       = 1'b0;
        end
    end

    // Saturating count of PC-stall cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en_c && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + CW'(1);
        end
    end

    // State, refill counter and stall counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= ST_RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_en       = pc_en_c;
    assign bus.en_ifid     = en_ifid_c;
    assign bus.en_idex     = en_idex_c;
    assign bus.en_exmem    = en_exmem_c;
    assign bus.en_memwb    = en_memwb_c;
    assign bus.flush_ifid  = flush_ifid_c;
    assign bus.flush_idex  = flush_idex_c;
    assign bus.flush_exmem = flush_exmem_c;
    assign bus.ifill       = ifill_c;
    assign bus.dfill       = dfill_c;
    assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: one instance with MISS_LAT=4/CW=16 and
// one with MISS_LAT=1/CW=2 for single-cycle refill and counter saturation.
module tb_pipe_stall_ctrl;

    // Control vector order: {pc,ifid,idex,exmem,memwb, fl_ifid,fl_idex,fl_exmem, ifill,dfill}
    localparam logic [9:0] V_OFF   = 10'b00000_000_00;
    localparam logic [9:0] V_RUN   = 10'b11111_000_00;
    localparam logic [9:0] V_DFILL = 10'b00000_000_01;
    localparam logic [9:0] V_BR    = 10'b11111_111_00;
    localparam logic [9:0] V_IMISS = 10'b00111_000_00;
    localparam logic [9:0] V_BUB   = 10'b00111_010_00;
    localparam logic [9:0] V_IFILL = 10'b00111_010_10;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    pipe_stall_ctrl_if #(.CW(16)) bus1 ();
    pipe_stall_ctrl_if #(.CW(2))  bus2 ();

    pipe_stall_ctrl #(.MISS_LAT(4), .CW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    pipe_stall_ctrl #(.MISS_LAT(1), .CW(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    logic [9:0] o1, o2;
    assign o1 = {bus1.pc_en, bus1.en_ifid, bus1.en_idex, bus1.en_exmem, bus1.en_memwb,
                 bus1.flush_ifid, bus1.flush_idex, bus1.flush_exmem, bus1.ifill, bus1.dfill};
    assign o2 = {bus2.pc_en, bus2.en_ifid, bus2.en_idex, bus2.en_exmem, bus2.en_memwb,
                 bus2.flush_ifid, bus2.flush_idex, bus2.flush_exmem, bus2.ifill, bus2.dfill};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply inputs after a negedge, check the controls, advance one cycle
    task automatic step(input int which, input logic ic, input logic mr, input logic dh,
                        input logic lu, input logic br, input logic [9:0] exp,
                        input string tag);
        if (which == 1) begin
            bus1.icache_hit = ic; bus1.mem_req = mr; bus1.dcache_hit = dh;
            bus1.ld_use = lu;     bus1.br_taken = br;
        end else begin
            bus2.icache_hit = ic; bus2.mem_req = mr; bus2.dcache_hit = dh;
            bus2.ld_use = lu;     bus2.br_taken = br;
        end
        #1;
        chk(tag, (which == 1) ? 32'(o1) : 32'(o2), 32'(exp));
        @(negedge clk);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        bus1.icache_hit = 1'b1; bus1.mem_req = 1'b0; bus1.dcache_hit = 1'b1;
        bus1.ld_use = 1'b0;     bus1.br_taken = 1'b0;
        bus2.icache_hit = 1'b1; bus2.mem_req = 1'b0; bus2.dcache_hit = 1'b1;
        bus2.ld_use = 1'b0;     bus2.br_taken = 1'b0;

        // Reset: controls forced low, counters clear
        #2;
        chk("rst_ctrl", 32'(o1), 32'(V_OFF));
        chk("rst_cnt", 32'(bus1.stall_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: free-running pipe
        for (int i = 0; i < 10; i++) step(1, 1, 0, 1, 0, 0, V_RUN, "t1_run");
        chk("t1_cnt", 32'(bus1.stall_cnt), 32'd0);

        // T2: D-miss freezes 5 cycles, dfill on the last, branch held in DWAIT
        step(1, 1, 1, 0, 0, 0, V_OFF,   "t2_miss");
        step(1, 1, 1, 0, 0, 1, V_OFF,   "t2_wait3_br");
        step(1, 1, 1, 0, 0, 0, V_OFF,   "t2_wait2");
        step(1, 1, 1, 0, 0, 0, V_OFF,   "t2_wait1");
        step(1, 1, 1, 0, 0, 0, V_DFILL, "t2_dfill");
        step(1, 1, 1, 1, 0, 0, V_RUN,   "t2_resume");
        chk("t2_cnt", 32'(bus1.stall_cnt), 32'd5);

        // T3: single load-use bubble
        step(1, 1, 0, 1, 1, 0, V_BUB, "t3_lduse");
        step(1, 1, 0, 1, 0, 0, V_RUN, "t3_after");
        chk("t3_cnt", 32'(bus1.stall_cnt), 32'd6);

        // T4: branch overrides same-cycle I-miss, no refill follows
        step(1, 0, 0, 1, 0, 1, V_BR, "t4_br_imiss");
        for (int i = 0; i < 5; i++) step(1, 1, 0, 1, 0, 0, V_RUN, "t4_noifill");
        chk("t4_cnt", 32'(bus1.stall_cnt), 32'd6);

        // T5: branch in the second IWAIT cycle aborts the refill
        step(1, 0, 0, 1, 0, 0, V_IMISS, "t5_imiss");
        step(1, 0, 0, 1, 0, 0, V_BUB,   "t5_iwait1");
        step(1, 0, 0, 1, 0, 1, V_BR,    "t5_iwait2_br");
        step(1, 1, 0, 1, 0, 0, V_RUN,   "t5_resume");
        chk("t5_cnt", 32'(bus1.stall_cnt), 32'd8);

        // Full I-refill with load-use on the miss and a D-miss mid-wait
        step(1, 0, 0, 1, 1, 0, V_BUB,   "i_miss_lduse");
        step(1, 0, 0, 1, 0, 0, V_BUB,   "i_wait3");
        step(1, 0, 1, 0, 0, 0, V_OFF,   "i_wait2_dmiss");
        step(1, 0, 0, 1, 0, 0, V_BUB,   "i_wait1");
        step(1, 0, 0, 1, 0, 0, V_IFILL, "i_ifill");
        step(1, 1, 0, 1, 0, 0, V_RUN,   "i_resume");
        chk("i_cnt", 32'(bus1.stall_cnt), 32'd13);

        // T6: reset asserted while DWAIT counter is at 2
        step(1, 1, 1, 0, 0, 0, V_OFF, "t6_miss");
        step(1, 1, 1, 0, 0, 0, V_OFF, "t6_wait3");
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ctrl", 32'(o1), 32'(V_OFF));
        chk("t6_rst_cnt", 32'(bus1.stall_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 0, 1, 0, 0, V_RUN, "t6_run");
        step(1, 1, 0, 1, 0, 0, V_RUN, "t6_run2");
        chk("t6_cnt", 32'(bus1.stall_cnt), 32'd0);

        // MISS_LAT=1: one-cycle wait; CW=2 counter saturates at 3
        chk("l1_cnt0", 32'(bus2.stall_cnt), 32'd0);
        step(2, 1, 1, 0, 0, 0, V_OFF,   "l1_miss");
        step(2, 1, 1, 0, 0, 0, V_DFILL, "l1_dfill");
        step(2, 1, 1, 1, 0, 0, V_RUN,   "l1_resume");
        chk("l1_cnt2", 32'(bus2.stall_cnt), 32'd2);
        for (int i = 0; i < 3; i++) step(2, 1, 0, 1, 1, 0, V_BUB, "sat_lduse");
        step(2, 1, 0, 1, 0, 0, V_RUN, "sat_run");
        chk("sat_cnt", 32'(bus2.stall_cnt), 32'd3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
